inst_cache_ctrl: RTL and testbench

//  Parametrised direct-mapped instruction cache with a multi-word line refill FSM.

---
 rtl/inst_cache_ctrl.sv | 140 ++++++++++++++
 tb/tb_inst_cache_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped instruction cache controller: registered hit path, in-order multi-word
// line refill from a request/ack memory port, and single-cycle whole-cache flush.
module inst_cache_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INST_W     = 32,
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  output logic              stall,
  output logic [INST_W-1:0] inst,
  output logic              cache_enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_data
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = ADDR_W - IdxW - OffW - 2;
  localparam logic [OffW-1:0] LastWord = OffW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRefill, StDone} state_e;

  state_e            state_q;
  logic [LINES-1:0]  valid_q;
  logic [OffW-1:0]   cnt_q;
  logic [OffW-1:0]   miss_off_q;
  logic [IdxW-1:0]   miss_idx_q;
  logic [TagW-1:0]   miss_tag_q;
  logic              flush_seen_q;

  logic [TagW-1:0]   tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES*LINE_WORDS];

  logic [OffW-1:0]   req_off;
  logic [IdxW-1:0]   req_idx;
  logic [TagW-1:0]   req_tag;
  logic              hit;
  logic              last_ack;
  logic              refill_ack;
  logic [INST_W-1:0] rd_data;
  logic [INST_W-1:0] miss_word;
  logic              unused_addr_bits;

  assign req_off = addr[OffW+1:2];
  assign req_idx = addr[OffW+IdxW+1:OffW+2];
  assign req_tag = addr[ADDR_W-1:OffW+IdxW+2];
  assign unused_addr_bits = ^addr[1:0];

  // A flush in the lookup cycle wins over a stale valid bit.
  assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;
  assign rd_data    = data_mem[{req_idx, req_off}];
  assign refill_ack = (state_q == StRefill) && mem_ack;
  assign last_ack   = refill_ack && (cnt_q == LastWord);

  // The missed word either arrives with this ack or was written earlier in the refill.
  assign miss_word = (cnt_q == miss_off_q) ? mem_data : data_mem[{miss_idx_q, miss_off_q}];

  always_ff @(posedge clk) begin
    if (refill_ack) begin
      data_mem[{miss_idx_q, cnt_q}] <= mem_data;
    end
    if (last_ack) begin
      tag_mem[miss_idx_q] <= miss_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      cnt_q        <= '0;
      miss_off_q   <= '0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
      flush_seen_q <= 1'b0;
      stall        <= 1'b0;
      cache_enable <= 1'b0;
      mem_req      <= 1'b0;
      inst         <= '0;
      mem_addr     <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end else if (last_ack && !flush_seen_q) begin
        valid_q[miss_idx_q] <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          cache_enable <= 1'b0;
          if (ce) begin
            if (hit) begin
              cache_enable <= 1'b1;
              inst         <= rd_data;
            end else begin
              state_q      <= StRefill;
              stall        <= 1'b1;
              mem_req      <= 1'b1;
              mem_addr     <= {req_tag, req_idx, {OffW{1'b0}}, 2'b00};
              miss_tag_q   <= req_tag;
              miss_idx_q   <= req_idx;
              miss_off_q   <= req_off;
              cnt_q        <= '0;
              flush_seen_q <= 1'b0;
            end
          end
        end
        StRefill: begin
          if (flush) begin
            flush_seen_q <= 1'b1;
          end
          if (mem_ack) begin
            cnt_q    <= cnt_q + OffW'(1);
            mem_addr <= mem_addr + ADDR_W'(4);
            if (cnt_q == LastWord) begin
              state_q      <= StDone;
              stall        <= 1'b0;
              mem_req      <= 1'b0;
              cache_enable <= 1'b1;
              inst         <= miss_word;
            end
          end
        end
        StDone: begin
          cache_enable <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Self-checking bench for inst_cache_ctrl: directed scenarios plus randomized fetches
// checked against a line-residency model and a fixed backing instruction memory.
`timescale 1ns/1ps
module tb_inst_cache_ctrl;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned LINES      = 64;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_BYTES = LINE_WORDS * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] mem_data = '0;
  logic        stall, cache_enable, mem_req;
  logic [31:0] inst, mem_addr;

  inst_cache_ctrl #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .LINES(LINES), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .flush(flush), .stall(stall),
    .inst(inst), .cache_enable(cache_enable), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Backing memory and residency model
  logic [31:0] preset [logic [31:0]];
  bit          m_valid [LINES];
  int unsigned m_line  [LINES];

  // Observations from the last fetch
  logic [31:0] req_q [$];
  logic [31:0] o_inst;
  bit          o_missed, o_proto_err, o_unstable, o_timeout, o_noresp;
  int          o_stall_cyc;

  function automatic logic [31:0] backing(input logic [31:0] a);
    if (preset.exists(a)) return preset[a];
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned ln = a / LINE_BYTES;
    return m_valid[ln % LINES] && (m_line[ln % LINES] == ln);
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void model_fill(input logic [31:0] a, input bit flushed);
    int unsigned ln = a / LINE_BYTES;
    if (flushed) model_flush();
    else begin
      m_valid[ln % LINES] = 1'b1;
      m_line[ln % LINES]  = ln;
    end
  endfunction

  // CPU + memory driver; records observations, does no judging.
  task automatic fetch(input logic [31:0] a, input int delay, input int flush_ack,
                       input bit flush_first);
    int w, words, cyc;
    bit fresh;
    logic [31:0] hold;
    req_q.delete();
    o_missed = 0; o_stall_cyc = 0; o_proto_err = 0; o_unstable = 0;
    o_timeout = 0; o_noresp = 0; o_inst = '0;
    ce = 1'b1; addr = a; flush = flush_first;
    @(posedge clk); #1;
    flush = 1'b0;
    if (cache_enable) begin
      o_inst = inst;
      if (stall || mem_req) o_proto_err = 1;
      ce = 1'b0;
      return;
    end
    if (!stall) begin
      o_noresp = 1;
      ce = 1'b0;
      return;
    end
    o_missed = 1; fresh = 1; w = 0; words = 0; cyc = 0; hold = '0;
    while (!cache_enable && cyc < 400) begin
      if (stall) o_stall_cyc++;
      if (!stall || !mem_req) o_proto_err = 1;
      if (mem_req) begin
        if (fresh) begin
          req_q.push_back(mem_addr);
          hold = mem_addr; fresh = 0; w = 0;
        end else if (mem_addr !== hold) o_unstable = 1;
        if (w >= delay) begin
          mem_ack = 1'b1; mem_data = backing(mem_addr); words++; fresh = 1;
          if (words == flush_ack) flush = 1'b1;
        end else w++;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; flush = 1'b0; cyc++;
    end
    ce = 1'b0;
    if (!cache_enable) begin
      o_timeout = 1;
      return;
    end
    o_inst = inst;
    if (stall || mem_req) o_proto_err = 1;
    @(posedge clk); #1;
    if (cache_enable || stall || mem_req) o_proto_err = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (cache_enable !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", cache_enable); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    ce = 1'b1; addr = 32'h300;
    @(posedge clk); #1;
    checks++; if ({stall, mem_req} !== 2'b11) begin errors++; $display("FAIL reset_refill_start: got %b want 11", {stall, mem_req}); end
    checks++; if (mem_addr !== 32'h300) begin errors++; $display("FAIL reset_refill_addr: got %h want 300", mem_addr); end
    for (int k = 0; k < 2; k++) begin
      mem_ack = 1'b1; mem_data = backing(mem_addr);
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    checks++; if (mem_addr !== 32'h308) begin errors++; $display("FAIL reset_mid_addr: got %h want 308", mem_addr); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({stall, mem_req} !== 2'b00) begin errors++; $display("FAIL reset_async: got %b want 00", {stall, mem_req}); end
    @(posedge clk); #1;
    checks++; if ({stall, mem_req, cache_enable} !== 3'b000) begin errors++; $display("FAIL reset_abort: got %b want 000", {stall, mem_req, cache_enable}); end
    ce = 1'b0; rst = 1'b1;
    model_flush();
    @(posedge clk); #1;
    fetch(32'h300, 0, -1, 0);
    checks++; if (o_missed !== 1'b1) begin errors++; $display("FAIL reset_refetch_miss: got %b want 1", o_missed); end
    checks++; if (o_inst !== backing(32'h300)) begin errors++; $display("FAIL reset_refetch_inst: got %h want %h", o_inst, backing(32'h300)); end
    model_fill(32'h300, 0);
  endtask

  task automatic test_cold_miss();
    for (int i = 0; i < 4; i++) preset[32'h100 + 4 * i] = 32'hA0 + i;
    fetch(32'h100, 0, -1, 0);
    checks++; if (o_missed !== 1'b1) begin errors++; $display("FAIL cold_missed: got %b want 1", o_missed); end
    checks++; if (req_q.size() != 4) begin errors++; $display("FAIL cold_req_count: got %0d want 4", req_q.size()); end
    for (int i = 0; i < req_q.size() && i < 4; i++) begin
      checks++;
      if (req_q[i] !== 32'h100 + 4 * i) begin
        errors++; $display("FAIL cold_req_addr%0d: got %h want %h", i, req_q[i], 32'h100 + 4 * i);
      end
    end
    checks++; if (o_inst !== 32'hA0) begin errors++; $display("FAIL cold_inst: got %h want a0", o_inst); end
    checks++; if (o_stall_cyc != 4) begin errors++; $display("FAIL cold_stall_cycles: got %0d want 4", o_stall_cyc); end
    checks++; if ({o_proto_err, o_timeout, o_noresp} !== 3'b000) begin errors++; $display("FAIL cold_protocol: got %b want 000", {o_proto_err, o_timeout, o_noresp}); end
    model_fill(32'h100, 0);
  endtask

  task automatic test_hit_streak();
    ce = 1'b1; addr = 32'h104;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({cache_enable, stall, mem_req} !== 3'b100 || inst !== 32'hA1 + i) begin
        errors++;
        $display("FAIL hit_streak%0d: got en/stall/req=%b inst=%h want 100 inst=%h",
                 i, {cache_enable, stall, mem_req}, inst, 32'hA1 + i);
      end
      addr = 32'h108 + 4 * i;
    end
    ce = 1'b0;
    @(posedge clk); #1;
    checks++; if (cache_enable !== 1'b0) begin errors++; $display("FAIL hit_idle_en: got %b want 0", cache_enable); end
    checks++; if (inst !== 32'hA3) begin errors++; $display("FAIL hit_idle_hold: got %h want a3", inst); end
  endtask

  task automatic test_conflict();
    logic [31:0] far_addr = 32'h100 + LINES * LINE_BYTES;
    fetch(32'h100, 0, -1, 0);
    checks++; if (o_missed !== 1'b0 || o_inst !== 32'hA0) begin errors++; $display("FAIL conflict_first_hit: got miss=%b inst=%h want miss=0 inst=a0", o_missed, o_inst); end
    fetch(far_addr, 0, -1, 0);
    checks++; if (o_missed !== 1'b1) begin errors++; $display("FAIL conflict_second_miss: got %b want 1", o_missed); end
    checks++; if (req_q.size() == 0 || req_q[0] !== far_addr) begin errors++; $display("FAIL conflict_req_addr: got %h want %h", (req_q.size() != 0) ? req_q[0] : 32'hx, far_addr); end
    model_fill(far_addr, 0);
    fetch(32'h100, 0, -1, 0);
    checks++; if (o_missed !== 1'b1 || o_inst !== 32'hA0) begin errors++; $display("FAIL conflict_refetch: got miss=%b inst=%h want miss=1 inst=a0", o_missed, o_inst); end
    model_fill(32'h100, 0);
  endtask

  task automatic test_flush_refill();
    fetch(32'h600, 0, 2, 0);
    checks++; if (o_missed !== 1'b1 || o_inst !== backing(32'h600)) begin errors++; $display("FAIL flushref_deliver: got miss=%b inst=%h want miss=1 inst=%h", o_missed, o_inst, backing(32'h600)); end
    model_fill(32'h600, 1);
    fetch(32'h600, 0, -1, 0);
    checks++; if (o_missed !== 1'b1 || req_q.size() == 0) begin errors++; $display("FAIL flushref_refetch_miss: got miss=%b reqs=%0d want miss=1 reqs>0", o_missed, req_q.size()); end
    model_fill(32'h600, 0);
  endtask

  task automatic test_delayed_ack();
    fetch(32'h208, 5, -1, 0);
    checks++; if (req_q.size() != 4) begin errors++; $display("FAIL delay_req_count: got %0d want 4", req_q.size()); end
    for (int i = 0; i < req_q.size() && i < 4; i++) begin
      checks++;
      if (req_q[i] !== 32'h200 + 4 * i) begin
        errors++; $display("FAIL delay_req_addr%0d: got %h want %h", i, req_q[i], 32'h200 + 4 * i);
      end
    end
    checks++; if (o_inst !== backing(32'h208)) begin errors++; $display("FAIL delay_inst: got %h want %h", o_inst, backing(32'h208)); end
    checks++; if (o_unstable !== 1'b0) begin errors++; $display("FAIL delay_addr_stable: got unstable=%b want 0", o_unstable); end
    checks++; if (o_stall_cyc != 24) begin errors++; $display("FAIL delay_stall_cycles: got %0d want 24", o_stall_cyc); end
    model_fill(32'h208, 0);
  endtask

  task automatic test_flush_idle();
    fetch(32'h20C, 0, -1, 0);
    checks++; if (o_missed !== 1'b0 || o_inst !== backing(32'h20C)) begin errors++; $display("FAIL flushidle_pre_hit: got miss=%b inst=%h want miss=0", o_missed, o_inst); end
    model_flush();
    fetch(32'h20C, 0, -1, 1);
    checks++; if (o_missed !== 1'b1) begin errors++; $display("FAIL flushidle_same_cycle: got miss=%b want 1", o_missed); end
    model_fill(32'h20C, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
    fetch(32'h100, 0, -1, 0);
    checks++; if (o_missed !== 1'b1 || o_inst !== 32'hA0) begin errors++; $display("FAIL flushidle_alone: got miss=%b inst=%h want miss=1 inst=a0", o_missed, o_inst); end
    model_fill(32'h100, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, base;
    int delay, fa;
    bit ff, exp_miss;
    for (int n = 0; n < 60; n++) begin
      a = 32'h4000 + $urandom_range(0, 3) * LINE_BYTES + $urandom_range(0, 2) * LINES * LINE_BYTES
          + $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
      base = a & ~(LINE_BYTES - 1);
      delay = $urandom_range(0, 2);
      fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : -1;
      ff = ($urandom_range(0, 9) == 0);
      if (ff) model_flush();
      exp_miss = !model_hit(a);
      fetch(a, delay, fa, ff);
      checks++; if (o_missed !== exp_miss) begin errors++; $display("FAIL rand%0d_miss a=%h: got %b want %b", n, a, o_missed, exp_miss); end
      checks++; if (o_inst !== backing(a & ~32'h3)) begin errors++; $display("FAIL rand%0d_inst a=%h: got %h want %h", n, a, o_inst, backing(a & ~32'h3)); end
      checks++; if ({o_proto_err, o_timeout, o_noresp, o_unstable} !== 4'b0000) begin errors++; $display("FAIL rand%0d_protocol: got %b want 0000", n, {o_proto_err, o_timeout, o_noresp, o_unstable}); end
      if (exp_miss) begin
        checks++;
        if (req_q.size() != LINE_WORDS || o_stall_cyc != int'(LINE_WORDS) * (delay + 1)) begin
          errors++; $display("FAIL rand%0d_refill_shape: got reqs=%0d stall=%0d want %0d/%0d", n, req_q.size(), o_stall_cyc, LINE_WORDS, LINE_WORDS * (delay + 1));
        end
        for (int i = 0; i < req_q.size(); i++) begin
          checks++;
          if (req_q[i] !== base + 4 * i) begin
            errors++; $display("FAIL rand%0d_req%0d: got %h want %h", n, i, req_q[i], base + 4 * i);
          end
        end
        model_fill(a, fa > 0);
      end
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
        checks++; if (cache_enable !== 1'b0) begin errors++; $display("FAIL rand%0d_idle_en: got %b want 0", n, cache_enable); end
      end
    end
  endtask

  initial begin
    model_flush();
    test_reset();
    test_cold_miss();
    test_hit_streak();
    test_conflict();
    test_flush_refill();
    test_delayed_ack();
    test_flush_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
